pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the RV32 core. Arbitrates redirect requests from execute and the interrupt controller, generates the 3-bit hold level and jump signals consumed by `program_counter` and the IF/ID/EX pipeline registers, and runs a multi-cycle flush window after every redirect. Also implements the JTAG halt handshake so the debugger only sees the core stopped at an instruction boundary.

---
 rtl/pipe_ctrl.sv | 112 +++++++++++
 tb/tb_pipe_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: redirect arbitration, hold levels, flush window
// after every redirect and the JTAG halt handshake at instruction boundaries.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_flag_ex_i,
    input  logic [31:0] jump_addr_ex_i,
    input  logic        int_assert_i,
    input  logic [31:0] int_addr_i,
    input  logic        hold_req_ex_i,
    input  logic        hold_req_bus_i,
    input  logic        jtag_halt_i,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic [2:0]  hold_flag_o,
    output logic        int_ack_o,
    output logic        halted_o
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_ALL  = 3'd3;
    localparam logic [2:0] CNT_LOAD  = 3'(FLUSH_CYCLES - 1);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        take_int, take_jump, redirect;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic [2:0]  hold_flag;

    // A halt request with an execute op still running must wait for it to retire.
    function automatic state_t halt_target(input logic ex_busy);
        return ex_busy ? DRAIN : HALTED;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold_flag = HOLD_NONE;
        take_int  = (state != HALTED) && int_assert_i;
        take_jump = (state != HALTED) && !int_assert_i && jump_flag_ex_i;
        redirect  = take_int || take_jump;
        jump_flag = redirect;
        jump_addr = take_int ? int_addr_i : (take_jump ? jump_addr_ex_i : 32'd0);

        case (state)
            RUN: begin
                if (hold_req_ex_i)
                    hold_flag = HOLD_ALL;
                else if (hold_req_bus_i)
                    hold_flag = HOLD_PC;
                if (jtag_halt_i)
                    state_nxt = halt_target(hold_req_ex_i);
            end
            FLUSH: begin
                hold_flag = HOLD_ALL;
                if (cnt == 3'd0)
                    state_nxt = jtag_halt_i ? halt_target(hold_req_ex_i) : RUN;
                else
                    cnt_nxt = cnt - 3'd1;
            end
            DRAIN: begin
                hold_flag = HOLD_ALL;
                if (!jtag_halt_i)
                    state_nxt = RUN;
                else if (!hold_req_ex_i)
                    state_nxt = HALTED;
            end
            HALTED: begin
                hold_flag = HOLD_ALL;
                if (!jtag_halt_i)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase

        // An accepted redirect overrides any halt decision and (re)starts the flush window.
        if (redirect) begin
            state_nxt = FLUSH;
            cnt_nxt   = CNT_LOAD;
            hold_flag = HOLD_ALL;
        end
    end

    // Outputs are forced quiet while reset is held, even the combinational paths.
    assign jump_flag_o = rst_n && jump_flag;
    assign jump_addr_o = rst_n ? jump_addr : 32'd0;
    assign hold_flag_o = rst_n ? hold_flag : HOLD_NONE;
    assign int_ack_o   = rst_n && take_int;
    assign halted_o    = rst_n && (state == HALTED);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with per-cycle expectation tables, then
// randomized traffic checked against a cycle-count based reference model.
module tb_pipe_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_flag_ex_i = 1'b0;
    logic [31:0] jump_addr_ex_i = 32'd0;
    logic        int_assert_i = 1'b0;
    logic [31:0] int_addr_i = 32'd0;
    logic        hold_req_ex_i = 1'b0;
    logic        hold_req_bus_i = 1'b0;
    logic        jtag_halt_i = 1'b0;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic [2:0]  hold_flag_o;
    logic        int_ack_o;
    logic        halted_o;
    logic [5:0]  obs;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: remaining flush cycles plus halt/drain flags.
    int m_flush_left;
    bit m_halted;
    bit m_drain;

    pipe_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .jump_flag_ex_i (jump_flag_ex_i),
        .jump_addr_ex_i (jump_addr_ex_i),
        .int_assert_i   (int_assert_i),
        .int_addr_i     (int_addr_i),
        .hold_req_ex_i  (hold_req_ex_i),
        .hold_req_bus_i (hold_req_bus_i),
        .jtag_halt_i    (jtag_halt_i),
        .jump_flag_o    (jump_flag_o),
        .jump_addr_o    (jump_addr_o),
        .hold_flag_o    (hold_flag_o),
        .int_ack_o      (int_ack_o),
        .halted_o       (halted_o)
    );

    assign obs = {jump_flag_o, int_ack_o, halted_o, hold_flag_o};

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        jump_flag_ex_i = 1'b0; jump_addr_ex_i = 32'd0;
        int_assert_i   = 1'b0; int_addr_i     = 32'd0;
        hold_req_ex_i  = 1'b0; hold_req_bus_i = 1'b0;
        jtag_halt_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        jump_flag_ex_i = 1'b1; jump_addr_ex_i = 32'h1234;
        int_assert_i = 1'b1; int_addr_i = 32'h8;
        hold_req_ex_i = 1'b1; hold_req_bus_i = 1'b1; jtag_halt_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== 6'd0 || jump_addr_o !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got flags=%b addr=%h, want flags=000000 addr=0", obs, jump_addr_o);
        end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== 6'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b want 000000", obs);
        end
        tick();
        hold_req_bus_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== 6'b000001) begin
            miscompares++;
            $display("FAIL bus_hold: got %b want 000001", obs);
        end
        tick();
        hold_req_bus_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== 6'd0) begin
            miscompares++;
            $display("FAIL bus_release: got %b want 000000", obs);
        end
        tick();
    endtask

    task automatic test_jump();
        logic [5:0] exp [4] = '{6'b100011, 6'b000011, 6'b000011, 6'b000000};
        jump_flag_ex_i = 1'b1; jump_addr_ex_i = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL jump_cycle%0d: got %b want %b", i, obs, exp[i]);
            end
            if (i == 0) begin
                vectors++;
                if (jump_addr_o !== 32'h100) begin
                    miscompares++;
                    $display("FAIL jump_addr: got %h want 00000100", jump_addr_o);
                end
            end
            tick();
            clear_inputs();
        end
    endtask

    task automatic test_int_priority();
        logic [5:0]  exp  [5] = '{6'b110011, 6'b100011, 6'b000011, 6'b000011, 6'b000000};
        logic [31:0] eadr [5] = '{32'h8, 32'h300, 32'h0, 32'h0, 32'h0};
        int_assert_i = 1'b1; int_addr_i = 32'h0000_0008;
        jump_flag_ex_i = 1'b1; jump_addr_ex_i = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp[i] || jump_addr_o !== eadr[i]) begin
                miscompares++;
                $display("FAIL int_prio_cycle%0d: got flags=%b addr=%h want flags=%b addr=%h",
                         i, obs, jump_addr_o, exp[i], eadr[i]);
            end
            tick();
            clear_inputs();
            if (i == 0) begin
                jump_flag_ex_i = 1'b1; jump_addr_ex_i = 32'h0000_0300;
            end
        end
    endtask

    task automatic test_halt_drain();
        bit         ex  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        bit         irq [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
        bit         jtg [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        logic [5:0] exp [8] = '{6'b000011, 6'b000011, 6'b000011, 6'b000011,
                                6'b000011, 6'b001011, 6'b001011, 6'b000000};
        for (int i = 0; i < 8; i++) begin
            hold_req_ex_i = ex[i]; int_assert_i = irq[i]; jtag_halt_i = jtg[i];
            int_addr_i = irq[i] ? 32'h40 : 32'h0;
            jump_flag_ex_i = irq[i];
            jump_addr_ex_i = irq[i] ? 32'h44 : 32'h0;
            @(negedge clk);
            vectors++;
            if (obs !== exp[i] || jump_addr_o !== 32'd0) begin
                miscompares++;
                $display("FAIL halt_drain_cycle%0d: got flags=%b addr=%h want flags=%b addr=0",
                         i, obs, jump_addr_o, exp[i]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_halt_in_flush();
        bit         jmp [5] = '{1, 0, 0, 0, 0};
        bit         jtg [5] = '{1, 1, 1, 0, 0};
        logic [5:0] exp [5] = '{6'b100011, 6'b000011, 6'b000011, 6'b001011, 6'b000000};
        for (int i = 0; i < 5; i++) begin
            jump_flag_ex_i = jmp[i]; jump_addr_ex_i = jmp[i] ? 32'h80 : 32'h0;
            jtag_halt_i = jtg[i];
            @(negedge clk);
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL halt_flush_cycle%0d: got %b want %b", i, obs, exp[i]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_in_halted();
        jtag_halt_i = 1'b1;
        tick();
        @(negedge clk);
        vectors++;
        if (obs !== 6'b001011) begin
            miscompares++;
            $display("FAIL halted_before_reset: got %b want 001011", obs);
        end
        #2;
        rst_n = 1'b0;
        jtag_halt_i = 1'b0;
        #1;
        vectors++;
        if (obs !== 6'd0) begin
            miscompares++;
            $display("FAIL async_reset_halted: got %b want 000000", obs);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (obs !== 6'd0) begin
                miscompares++;
                $display("FAIL run_after_reset%0d: got %b want 000000", i, obs);
            end
            tick();
        end
    endtask

    task automatic model_expect(output logic ej, output logic [31:0] ea, output logic [2:0] eh,
                                output logic eack, output logic ehalt);
        bit accept;
        accept = !m_halted && (int_assert_i || jump_flag_ex_i);
        ej    = accept;
        eack  = accept && int_assert_i;
        ea    = !accept ? 32'd0 : (int_assert_i ? int_addr_i : jump_addr_ex_i);
        ehalt = m_halted;
        if (accept || m_halted || m_drain || m_flush_left > 0 || hold_req_ex_i)
            eh = 3'd3;
        else if (hold_req_bus_i)
            eh = 3'd1;
        else
            eh = 3'd0;
    endtask

    task automatic model_advance();
        bit accept;
        accept = !m_halted && (int_assert_i || jump_flag_ex_i);
        if (accept) begin
            m_flush_left = FC;
            m_drain = 1'b0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0 && jtag_halt_i) begin
                if (hold_req_ex_i) m_drain = 1'b1;
                else m_halted = 1'b1;
            end
        end else if (m_halted) begin
            if (!jtag_halt_i) m_halted = 1'b0;
        end else if (m_drain) begin
            if (!jtag_halt_i) m_drain = 1'b0;
            else if (!hold_req_ex_i) begin
                m_drain = 1'b0;
                m_halted = 1'b1;
            end
        end else if (jtag_halt_i) begin
            if (hold_req_ex_i) m_drain = 1'b1;
            else m_halted = 1'b1;
        end
    endtask

    task automatic test_random();
        logic        ej, eack, ehalt;
        logic [31:0] ea;
        logic [2:0]  eh;
        bit          acked;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
        m_flush_left = 0; m_halted = 1'b0; m_drain = 1'b0;
        acked = 1'b0;
        for (int i = 0; i < 600; i++) begin
            jump_flag_ex_i = ($urandom_range(0, 3) == 0);
            jump_addr_ex_i = $urandom;
            int_assert_i   = !acked && ($urandom_range(0, 6) == 0);
            int_addr_i     = $urandom;
            hold_req_ex_i  = ($urandom_range(0, 2) == 0);
            hold_req_bus_i = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) jtag_halt_i = !jtag_halt_i;
            @(negedge clk);
            model_expect(ej, ea, eh, eack, ehalt);
            vectors++;
            if ({jump_flag_o, int_ack_o, halted_o, hold_flag_o} !== {ej, eack, ehalt, eh}
                || jump_addr_o !== ea) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got j=%b ack=%b halt=%b hold=%0d addr=%h want j=%b ack=%b halt=%b hold=%0d addr=%h",
                         i, jump_flag_o, int_ack_o, halted_o, hold_flag_o, jump_addr_o,
                         ej, eack, ehalt, eh, ea);
            end
            acked = eack;
            @(posedge clk);
            model_advance();
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_jump();
        test_int_priority();
        test_halt_drain();
        test_halt_in_flush();
        test_reset_in_halted();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
